div_iter32: RTL and testbench

- Sequential radix-2 restoring integer divider for the EX stage; the inverse counterpart of the Booth partial-product multiplier datapath.
- Serves div.w, mod.w, div.wu and mod.wu: one request in, quotient and remainder out.
- Signed and unsigned 32-bit operands; produces one quotient bit per cycle.
- Valid/ready handshake on both sides; pipeline flush via cancel.

---
 rtl/div_iter32.sv | 129 ++++++++++++
 tb/tb_div_iter32.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_iter32.sv
// Sequential radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu); one quotient bit per cycle.
// Optional macro DIV_SMALL_BYPASS_EN: when |x| < |y| skip the iterations and go straight to FIX.
module div_iter32 #(
   parameter int DIV_W      = 32,
   parameter int ITER_CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic             div_signed,
   input  logic [DIV_W-1:0] x,
   input  logic [DIV_W-1:0] y,
   input  logic             cancel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   // Handshake: a request is taken on a rising edge where div_valid && div_ready && !cancel;
   // a result is released on a rising edge where out_valid && out_ready.
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   localparam logic [DIV_W-1:0]      ONE       = 1;
   localparam logic [ITER_CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(DIV_W - 1);

   state_t                  state, next_state;
   logic [DIV_W-1:0]        x_q, y_q;
   logic                    signed_q;
   logic                    sign_q, sign_r;
   logic [2*DIV_W-1:0]      pr;
   logic [ITER_CNT_W-1:0]   cnt;
   logic [DIV_W-1:0]        abs_x, abs_y;
   logic [DIV_W:0]          trial;

   assign abs_x = (signed_q && x_q[DIV_W-1]) ? (~x_q + ONE) : x_q;
   assign abs_y = (signed_q && y_q[DIV_W-1]) ? (~y_q + ONE) : y_q;
   // Shifted upper 33 bits of the partial remainder minus the divisor.
   assign trial = pr[2*DIV_W-1:DIV_W-1] - {1'b0, abs_y};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (cancel) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: if (div_valid) next_state = PREP;
            PREP: begin
               if (y_q == '0) next_state = DONE;
`ifdef DIV_SMALL_BYPASS_EN
               else if (abs_x < abs_y) next_state = FIX;
`endif
               else next_state = ITER;
            end
            ITER: if (cnt == LAST_ITER) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      div_ready = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q         <= '0;
         y_q         <= '0;
         signed_q    <= 1'b0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         pr          <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (!cancel) begin
         case (state)
            IDLE: begin
               if (div_valid) begin
                  x_q      <= x;
                  y_q      <= y;
                  signed_q <= div_signed;
               end
            end
            PREP: begin
               sign_q <= signed_q & (x_q[DIV_W-1] ^ y_q[DIV_W-1]);
               sign_r <= signed_q & x_q[DIV_W-1];
               cnt    <= '0;
               if (y_q == '0) begin
                  quotient    <= '1;
                  remainder   <= x_q;
                  div_by_zero <= 1'b1;
               end else begin
                  div_by_zero <= 1'b0;
                  pr          <= {{DIV_W{1'b0}}, abs_x};
`ifdef DIV_SMALL_BYPASS_EN
                  if (abs_x < abs_y) pr <= {abs_x, {DIV_W{1'b0}}};
`endif
               end
            end
            ITER: begin
               if (!trial[DIV_W]) pr <= {trial[DIV_W-1:0], pr[DIV_W-2:0], 1'b1};
               else               pr <= {pr[2*DIV_W-2:0], 1'b0};
               cnt <= cnt + CNT_ONE;
            end
            FIX: begin
               quotient  <= sign_q ? (~pr[DIV_W-1:0] + ONE) : pr[DIV_W-1:0];
               remainder <= sign_r ? (~pr[2*DIV_W-1:DIV_W] + ONE) : pr[2*DIV_W-1:DIV_W];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter32.sv
// Bench for div_iter32: directed corner cases plus random operands against an arithmetic model.
module tb_div_iter32;

   logic        clk, resetn;
   logic        div_valid, div_ready, div_signed, cancel;
   logic        out_valid, out_ready, div_by_zero, busy;
   logic [31:0] x, y, quotient, remainder;

   int total = 0;
   int bad   = 0;

   div_iter32 dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_signed (div_signed),
      .x          (x),
      .y          (y),
      .cancel     (cancel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division; latency from the architectural rules.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat);
      longint sa, sb;
      logic [31:0] ma, mb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 2;
      end else begin
         z = 1'b0;
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
         end else begin
            q = a / b;
            r = a % b;
         end
         ma = (s && a[31]) ? 32'(-longint'($signed(a))) : a;
         mb = (s && b[31]) ? 32'(-longint'($signed(b))) : b;
`ifdef DIV_SMALL_BYPASS_EN
         lat = (ma < mb) ? 3 : 35;
`else
         lat = (ma < mb) ? 35 : 35;
`endif
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit hold, input string tag);
      logic [31:0] eq, er;
      logic        ez;
      int          el, n;
      model(a, b, s, eq, er, ez, el);
      out_ready = !hold;
      @(negedge clk);
      x = a; y = b; div_signed = s; div_valid = 1'b1;
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      x = $urandom; y = $urandom; div_signed = 1'($urandom_range(0, 1));
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
      chk({tag, ".lat"}, n, el);
      chk({tag, ".q"}, quotient, eq);
      chk({tag, ".r"}, remainder, er);
      chk({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
      if (hold) begin
         repeat (10) begin
            @(negedge clk);
            chk({tag, ".hold_v"}, {31'b0, out_valid}, 32'd1);
            chk({tag, ".hold_q"}, quotient, eq);
            chk({tag, ".hold_r"}, remainder, er);
            chk({tag, ".hold_rdy"}, {31'b0, div_ready}, 32'd0);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      chk({tag, ".drop_v"}, {31'b0, out_valid}, 32'd0);
      chk({tag, ".idle_rdy"}, {31'b0, div_ready}, 32'd1);
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3, 4:    v = 32'($urandom_range(1, 40));
         5: begin
            v = 32'($urandom_range(1, 40));
            v = ~v + 32'd1;
         end
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int seen;
      logic [31:0] ra, rb;
      logic        rs;
      div_valid = 1'b0; div_signed = 1'b0; cancel = 1'b0; out_ready = 1'b1;
      x = '0; y = '0;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("rst.valid", {31'b0, out_valid}, 32'd0);
      chk("rst.busy", {31'b0, busy}, 32'd0);
      chk("rst.q", quotient, 32'd0);
      chk("rst.r", remainder, 32'd0);
      chk("rst.dbz", {31'b0, div_by_zero}, 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst.ready", {31'b0, div_ready}, 32'd1);

      run_op(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "s_m7_2");
      run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "u_m7_2");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_ovf");
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "u_max_1");
      run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, "dbz");
      run_op(32'd5, 32'd9, 1'b0, 1'b0, "u5_9");
      run_op(32'hFFFF_FFFB, 32'd9, 1'b1, 1'b0, "s_m5_9");
      run_op(32'd1000, 32'd33, 1'b0, 1'b1, "hold");

      // Cancel in the middle of the iterations.
      @(negedge clk);
      x = 32'd77; y = 32'd5; div_signed = 1'b0; div_valid = 1'b1;
      @(posedge clk);
      #1 div_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      @(negedge clk);
      chk("cancel.busy", {31'b0, busy}, 32'd0);
      chk("cancel.ready", {31'b0, div_ready}, 32'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("cancel.no_result", seen, 32'd0);
      run_op(32'd9, 32'd3, 1'b0, 1'b0, "after_cancel");

      // Cancel in the same cycle as an accept drops the request.
      @(negedge clk);
      x = 32'd50; y = 32'd2; div_valid = 1'b1; cancel = 1'b1;
      @(negedge clk);
      div_valid = 1'b0; cancel = 1'b0;
      chk("cancel_acc.busy", {31'b0, busy}, 32'd0);
      chk("cancel_acc.ready", {31'b0, div_ready}, 32'd1);

      // Asynchronous reset in the middle of the iterations.
      @(negedge clk);
      x = 32'd1000; y = 32'd3; div_signed = 1'b0; div_valid = 1'b1;
      @(posedge clk);
      #1 div_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst.valid", {31'b0, out_valid}, 32'd0);
      chk("arst.busy", {31'b0, busy}, 32'd0);
      chk("arst.q", quotient, 32'd0);
      chk("arst.r", remainder, 32'd0);
      chk("arst.ready", {31'b0, div_ready}, 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      run_op(32'd1000, 32'd3, 1'b0, 1'b0, "after_arst");

      for (int i = 0; i < 40; i++) begin
         ra = pick_val();
         rb = pick_val();
         rs = 1'($urandom_range(0, 1));
         run_op(ra, rb, rs, 1'b0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
